spi_controller: RTL
===================

// Module: spi_controller
// PURPOSE
//  SPI mode-0 write-only controller; drives SCLK/COPI/nCS into the spi_peripheral register bank.
//  - Accepts one {addr, data} request per valid/ready handshake.
//  - Serialises it as a 16-bit frame {1'b1 (write), addr[6:0], data[7:0]}, MSB first.
//  - Used by the on-chip sequencer and the bench to program the output, PWM-enable and duty-cycle registers.
// PARAMETERS
//  CLK_DIV         4    clk cycles per SCLK half-period; legal range >= 2
//  MAX_VALID_ADDR  7'd4 highest legal register address; used only when SPI_CTRL_ADDR_CHECK_EN is defined
// PORTS
//  clk        in   1  system clock; the only clock in the block
//  rst        in   1  reset, synchronous, active-high
//  req_valid  in   1  request present
//  req_ready  out  1  controller can accept a request; high only in IDLE
//  req_addr   in   7  target register address
//  req_data   in   8  write data
//  sclk       out  1  SPI clock; idles low
//  copi       out  1  serial data, controller to peripheral
//  ncs        out  1  chip select, active-low; idles high
//  busy       out  1  high from the cycle after accept until IDLE is re-entered
//  done       out  1  one-cycle pulse: frame complete, ncs has just risen
//  err        out  1  one-cycle pulse: request rejected (SPI_CTRL_ADDR_CHECK_EN only)
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: sclk=0, copi=0, ncs=1, busy=0, done=0, err=0, req_ready=1; state=IDLE.
//  - Reset is honoured mid-frame. On the next edge, ncs=1 and sclk=0, the shift register and counters
//    clear, and no done pulse is issued. The peripheral discards the short frame (fewer than 16 bits).
//  - FSM state transitions:
//    * IDLE: accept when req_valid && req_ready, then latch shreg = {1'b1, req_addr, req_data},
//      set bit_cnt = 0, and go to SETUP.
//    * SETUP: ncs=0, sclk=0, copi=shreg[15]; lasts CLK_DIV cycles, then goes to HIGH.
//    * HIGH: sclk=1; copi held stable; lasts CLK_DIV cycles. At the end:
//      bit_cnt==15 -> HOLD; otherwise bit_cnt += 1 and go to LOW.
//    * LOW: sclk=0; copi advances to the next bit on entry (shreg shifts left); lasts CLK_DIV cycles, then HIGH.
//    * HOLD: sclk=0, ncs=0; lasts CLK_DIV cycles, then GAP.
//    * GAP: ncs=1, and done=1 in the first GAP cycle only; lasts CLK_DIV cycles, then IDLE with req_ready=1.
//  - Phase timing: a single down-counter div_cnt is loaded with CLK_DIV-1 on each state entry;
//    the state advances when div_cnt==0.
//  - Latency, with accept at cycle 0:
//    * ncs falls at cycle 1;
//    * 16 sclk rising edges occur, the first at cycle 1+CLK_DIV;
//    * ncs rises and done pulses at cycle 1+33*CLK_DIV;
//    * req_ready returns at cycle 1+34*CLK_DIV.
//  - COPI changes only while sclk is low, at least CLK_DIV cycles before each rising edge.
//    This satisfies the peripheral's 2-flop synchroniser timing.
//  - Handshake rules:
//    * req_valid while busy is ignored; there is no queueing and the requester must hold until ready.
//    * Back-to-back requests are separated by at least a CLK_DIV-cycle nCS-high gap.
//  - Request fields are sampled only at accept; later changes to req_addr/req_data do not affect the frame.
//  - Counter widths: bit_cnt is 4 bits; div_cnt is $clog2(CLK_DIV) bits, minimum 1.
// CONFIGURATION
//  SPI_CTRL_ADDR_CHECK_EN
//  - Defined: an accepted request with req_addr > MAX_VALID_ADDR generates no frame.
//    * ncs stays 1 and sclk stays 0;
//    * err pulses high for one cycle, the cycle after accept;
//    * FSM goes IDLE -> GAP (CLK_DIV cycles) -> IDLE; done is not pulsed.
//  - Undefined: err is tied 0 and every address is transmitted unchanged.
// TESTING
//  - Benches use CLK_DIV=4; the peripheral is connected as the loopback target.
//  1. Write addr 0x00, data 0xA5:
//     * COPI sampled at the 16 rising edges = 1000_0000_1010_0101;
//     * ncs is low for 132 cycles, done pulses once;
//     * peripheral en_reg_out_7_0 = 0xA5.
//  2. Back-to-back writes, addr 0x04 data 0x80 then addr 0x02 data 0xFF, with req_valid held high:
//     * second accept occurs 4 cycles after done;
//     * pwm_duty_cycle = 0x80 and en_reg_pwm_7_0 = 0xFF.
//  3. req_valid pulsed mid-frame with addr 0x01 data 0x3C:
//     * not accepted; req_ready stays 0;
//     * en_reg_out_15_8 is unchanged (0x00).
//  4. rst asserted after the 7th sclk rising edge of a write to addr 0x00, data 0x55:
//     * next cycle: ncs=1, sclk=0, busy=0, no done pulse;
//     * peripheral registers remain 0x00.
//  5. Macro defined, write addr 0x05 data 0x11:
//     * err pulses once; ncs never falls; done stays 0;
//     * req_ready returns 5 cycles after accept.
//  6. Macro undefined, same request as test 5:
//     * full 16-bit frame is sent; err stays 0;
//     * peripheral ignores the address and all registers are unchanged.

Source files
------------

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0, write-only controller for the spi_peripheral register bank.
// Each accepted {addr, data} request is sent as a 16-bit frame {1'b1, addr[6:0], data[7:0]}, MSB first.
//
// Parameters:
//   CLK_DIV         clk cycles per SCLK half-period (>= 2)
//   MAX_VALID_ADDR  highest legal register address (used only with SPI_CTRL_ADDR_CHECK_EN)
//
// Ports:
//   clk, rst              system clock; synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_addr, req_data    register address / write data, sampled at accept
//   sclk, copi, ncs       SPI bus (sclk idles low, ncs idles high)
//   busy                  frame or gap in progress
//   done                  one-cycle pulse as ncs rises at end of a frame
//   err                   one-cycle pulse on a rejected request
//
// Build option: define SPI_CTRL_ADDR_CHECK_EN to reject requests with req_addr > MAX_VALID_ADDR
// (no frame, err pulse, IDLE -> GAP -> IDLE). Without it err is constant 0 and every address is sent.

module spi_controller #(
    parameter int unsigned CLK_DIV        = 4,
    parameter logic [6:0]  MAX_VALID_ADDR = 7'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       sclk,
    output logic       copi,
    output logic       ncs,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t               state;
    logic [FRAME_W-1:0]   shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DIV_W-1:0]     div_cnt;
    logic                 phase_end_c;
    logic                 addr_bad_c;

    assign phase_end_c = (div_cnt == '0);

    // Address filter for rejected requests
`ifdef SPI_CTRL_ADDR_CHECK_EN
    assign addr_bad_c = (req_addr > MAX_VALID_ADDR);
`else
    logic unused_max_addr;
    assign addr_bad_c      = 1'b0;
    assign unused_max_addr = ^MAX_VALID_ADDR;
`endif

    // Controller FSM; every bus/status output is updated on the edge that enters a state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            sclk      <= 1'b0;
            copi      <= 1'b0;
            ncs       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            // Phase timer; a state transition below reloads it
            if (!phase_end_c) begin
                div_cnt <= div_cnt - DIV_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        div_cnt   <= DIV_LOAD;
                        if (addr_bad_c) begin
                            err   <= 1'b1;
                            state <= ST_GAP;
                        end else begin
                            shreg   <= {1'b1, req_addr, req_data};
                            bit_cnt <= '0;
                            ncs     <= 1'b0;
                            sclk    <= 1'b0;
                            copi    <= 1'b1;
                            state   <= ST_SETUP;
                        end
                    end
                end

                ST_SETUP: begin
                    if (phase_end_c) begin
                        sclk    <= 1'b1;
                        div_cnt <= DIV_LOAD;
                        state   <= ST_HIGH;
                    end
                end

                ST_HIGH: begin
                    if (phase_end_c) begin
                        sclk    <= 1'b0;
                        div_cnt <= DIV_LOAD;
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_HOLD;
                        end else begin
                            // Next bit goes out on the falling edge, a full phase before the next rise
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                            copi    <= shreg[FRAME_W-2];
                            state   <= ST_LOW;
                        end
                    end
                end

                ST_LOW: begin
                    if (phase_end_c) begin
                        sclk    <= 1'b1;
                        div_cnt <= DIV_LOAD;
                        state   <= ST_HIGH;
                    end
                end

                ST_HOLD: begin
                    if (phase_end_c) begin
                        ncs     <= 1'b1;
                        done    <= 1'b1;
                        div_cnt <= DIV_LOAD;
                        state   <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (phase_end_c) begin
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    ncs       <= 1'b1;
                    sclk      <= 1'b0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
